// File: rtl/glb_banked_dpram_pkg.sv
// glb_pkg: shared types, read-during-write constants and address helpers for the banked GLB RAM
package glb_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;
  localparam int RDW_READ_FIRST = 0;
  localparam int RDW_WRITE_FIRST = 1;
  function automatic int unsigned bank_of(input int unsigned addr, input int unsigned nb);
    return addr % nb;
  endfunction
  function automatic int unsigned idx_of(input int unsigned addr, input int unsigned nb);
    return addr / nb;
  endfunction
endpackage

// File: rtl/glb_banked_dpram_if.sv
// glb_banked_dpram_if: two-port access bus plus bulk-clear handshake of the banked GLB RAM
interface glb_banked_dpram_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic clr_start, clr_busy, clr_done, collision;
  logic we_a, re_a, rvalid_a, we_b, re_b, rvalid_b;
  logic [ADDR_WIDTH-1:0] addr_a, addr_b;
  logic [DATA_WIDTH-1:0] wdata_a, rdata_a, wdata_b, rdata_b;
  modport master (
    output clr_start, we_a, re_a, addr_a, wdata_a, we_b, re_b, addr_b, wdata_b,
    input  clr_busy, clr_done, collision, rdata_a, rvalid_a, rdata_b, rvalid_b
  );
  modport slave (
    input  clr_start, we_a, re_a, addr_a, wdata_a, we_b, re_b, addr_b, wdata_b,
    output clr_busy, clr_done, collision, rdata_a, rvalid_a, rdata_b, rvalid_b
  );
endinterface

// File: rtl/glb_banked_dpram_bank.sv
// glb_dpram_bank: one true dual-port bank with registered reads and selectable cross-port read-during-write
module glb_dpram_bank
  import glb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 64,
  parameter int RDW_MODE = RDW_READ_FIRST
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_we_a,
  input  logic i_re_a,
  input  logic [$clog2(DEPTH)-1:0] i_addr_a,
  input  logic [DATA_WIDTH-1:0] i_wdata_a,
  output logic [DATA_WIDTH-1:0] o_rdata_a,
  input  logic i_we_b,
  input  logic i_re_b,
  input  logic [$clog2(DEPTH)-1:0] i_addr_b,
  input  logic [DATA_WIDTH-1:0] i_wdata_b,
  output logic [DATA_WIDTH-1:0] o_rdata_b
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_q_a, r_q_b;
  logic w_fwd_a, w_fwd_b;
  // only the other port's write can be forwarded; a port's own write always reads old data
  assign w_fwd_a = (RDW_MODE == RDW_WRITE_FIRST) && i_we_b && (i_addr_b == i_addr_a);
  assign w_fwd_b = (RDW_MODE == RDW_WRITE_FIRST) && i_we_a && (i_addr_a == i_addr_b);
  always_ff @(posedge clk) begin
    if (i_we_a) r_mem[i_addr_a] <= i_wdata_a;
    if (i_we_b) r_mem[i_addr_b] <= i_wdata_b;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q_a <= '0;
      r_q_b <= '0;
    end else begin
      if (i_re_a) r_q_a <= w_fwd_a ? i_wdata_b : r_mem[i_addr_a];
      if (i_re_b) r_q_b <= w_fwd_b ? i_wdata_a : r_mem[i_addr_b];
    end
  end
  assign o_rdata_a = r_q_a;
  assign o_rdata_b = r_q_b;
endmodule

// File: rtl/glb_banked_dpram.sv
// glb_banked_dpram: low-order-interleaved multi-bank dual-port RAM with read pipeline, collision flag and bulk clear
module glb_banked_dpram
  import glb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_BANKS = 4,
  parameter int BANK_DEPTH = 64,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE = RDW_READ_FIRST
) (
  input logic clk,
  input logic rst_n,
  glb_banked_dpram_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(NUM_BANKS * BANK_DEPTH);
  localparam int BSEL_W = $clog2(NUM_BANKS);
  localparam int IDX_W = $clog2(BANK_DEPTH);
  localparam int SW = (BSEL_W > 0) ? BSEL_W : 1;
  clr_state_t r_state;
  logic [IDX_W-1:0] r_idx, w_idx_a, w_idx_b;
  logic [ADDR_WIDTH-1:0] w_addr_a, w_addr_b;
  logic [SW-1:0] w_bank_a, w_bank_b, r_bs_a, r_bs_b;
  logic r_busy, r_done, r_coll, r_v_a, r_v_b;
  logic w_we_a, w_re_a, w_we_b, w_re_b, w_coll, w_clr;
  logic [DATA_WIDTH-1:0] w_q_a [NUM_BANKS];
  logic [DATA_WIDTH-1:0] w_q_b [NUM_BANKS];
  logic [DATA_WIDTH-1:0] w_mux_a, w_mux_b;
  assign w_addr_a = bus.addr_a;
  assign w_addr_b = bus.addr_b;
  assign w_bank_a = SW'(bank_of(32'(w_addr_a), NUM_BANKS));
  assign w_bank_b = SW'(bank_of(32'(w_addr_b), NUM_BANKS));
  assign w_idx_a = IDX_W'(idx_of(32'(w_addr_a), NUM_BANKS));
  assign w_idx_b = IDX_W'(idx_of(32'(w_addr_b), NUM_BANKS));
  assign w_we_a = bus.we_a & ~r_busy;
  assign w_re_a = bus.re_a & ~r_busy;
  assign w_we_b = bus.we_b & ~r_busy;
  assign w_re_b = bus.re_b & ~r_busy;
  assign w_coll = w_we_a & w_we_b & (w_addr_a == w_addr_b);
  // a reset landing mid-clear must not zero the word of that cycle
  assign w_clr = (r_state == CLEAR) & rst_n;
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    glb_dpram_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH(BANK_DEPTH),
      .RDW_MODE(RDW_MODE)
    ) u_bank (
      .clk(clk),
      .rst_n(rst_n),
      .i_we_a(w_clr | (w_we_a & (w_bank_a == SW'(g)))),
      .i_re_a(w_re_a & (w_bank_a == SW'(g))),
      .i_addr_a(w_clr ? r_idx : w_idx_a),
      .i_wdata_a(w_clr ? '0 : bus.wdata_a),
      .o_rdata_a(w_q_a[g]),
      .i_we_b(w_we_b & ~w_coll & (w_bank_b == SW'(g))),
      .i_re_b(w_re_b & (w_bank_b == SW'(g))),
      .i_addr_b(w_idx_b),
      .i_wdata_b(bus.wdata_b),
      .o_rdata_b(w_q_b[g])
    );
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.clr_start) begin
          r_state <= CLEAR;
          r_idx <= '0;
          r_busy <= 1'b1;
        end
        CLEAR: begin
          r_idx <= r_idx + 1'b1;
          if (r_idx == IDX_W'(BANK_DEPTH - 1)) begin
            r_state <= DONE;
            r_done <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  // bank select only moves on a read so the muxed output holds between reads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v_a <= 1'b0;
      r_v_b <= 1'b0;
      r_bs_a <= '0;
      r_bs_b <= '0;
      r_coll <= 1'b0;
    end else begin
      r_v_a <= w_re_a;
      r_v_b <= w_re_b;
      r_coll <= w_coll;
      if (w_re_a) r_bs_a <= w_bank_a;
      if (w_re_b) r_bs_b <= w_bank_b;
    end
  end
  assign w_mux_a = w_q_a[r_bs_a];
  assign w_mux_b = w_q_b[r_bs_b];
  if (READ_LATENCY == 2) begin : g_lat2
    logic r_v2_a, r_v2_b;
    logic [DATA_WIDTH-1:0] r_d2_a, r_d2_b;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_v2_a <= 1'b0;
        r_v2_b <= 1'b0;
        r_d2_a <= '0;
        r_d2_b <= '0;
      end else begin
        r_v2_a <= r_v_a;
        r_v2_b <= r_v_b;
        if (r_v_a) r_d2_a <= w_mux_a;
        if (r_v_b) r_d2_b <= w_mux_b;
      end
    end
    assign bus.rdata_a = r_d2_a;
    assign bus.rdata_b = r_d2_b;
    assign bus.rvalid_a = r_v2_a;
    assign bus.rvalid_b = r_v2_b;
  end else begin : g_lat1
    assign bus.rdata_a = w_mux_a;
    assign bus.rdata_b = w_mux_b;
    assign bus.rvalid_a = r_v_a;
    assign bus.rvalid_b = r_v_b;
  end
  assign bus.clr_busy = r_busy;
  assign bus.clr_done = r_done;
  assign bus.collision = r_coll;
endmodule

// File: tb/tb_glb_banked_dpram.sv
// tb_glb_banked_dpram: random and directed scoreboard bench for two configurations of the banked GLB RAM
module tb_glb_banked_dpram;
  localparam int DW = 16, NB = 4, BD = 64, AW = 8, NW = NB * BD;
  typedef struct { logic [DW-1:0] d; int due; } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic clr_start = 1'b0, we_a = 1'b0, re_a = 1'b0, we_b = 1'b0, re_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] wdata_a = '0, wdata_b = '0;
  int cyc = 0, n_chk = 0, n_err = 0, ctr = 0;
  logic e_coll = 1'b0;
  logic [DW-1:0] mem [NW];
  exp_t q [4][$];
  logic rv [4];
  logic [DW-1:0] rd [4];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  glb_banked_dpram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0 ();
  glb_banked_dpram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();
  assign if0.clr_start = clr_start;
  assign if0.we_a = we_a;
  assign if0.re_a = re_a;
  assign if0.addr_a = addr_a;
  assign if0.wdata_a = wdata_a;
  assign if0.we_b = we_b;
  assign if0.re_b = re_b;
  assign if0.addr_b = addr_b;
  assign if0.wdata_b = wdata_b;
  assign if1.clr_start = clr_start;
  assign if1.we_a = we_a;
  assign if1.re_a = re_a;
  assign if1.addr_a = addr_a;
  assign if1.wdata_a = wdata_a;
  assign if1.we_b = we_b;
  assign if1.re_b = re_b;
  assign if1.addr_b = addr_b;
  assign if1.wdata_b = wdata_b;
  glb_banked_dpram #(.DATA_WIDTH(DW), .NUM_BANKS(NB), .BANK_DEPTH(BD), .READ_LATENCY(1), .RDW_MODE(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  glb_banked_dpram #(.DATA_WIDTH(DW), .NUM_BANKS(NB), .BANK_DEPTH(BD), .READ_LATENCY(2), .RDW_MODE(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  assign rv[0] = if0.rvalid_a;
  assign rv[1] = if0.rvalid_b;
  assign rv[2] = if1.rvalid_a;
  assign rv[3] = if1.rvalid_b;
  assign rd[0] = if0.rdata_a;
  assign rd[1] = if0.rdata_b;
  assign rd[2] = if1.rdata_a;
  assign rd[3] = if1.rdata_b;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // scoreboard monitor: streams 0/1 are dut0 ports A/B, 2/3 are dut1 ports A/B
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rv[i] === 1'b1) begin
        if (q[i].size() == 0) chk($sformatf("rvalid%0d_unexpected", i), 32'(rv[i]), 0);
        else begin
          exp_t e;
          e = q[i].pop_front();
          chk($sformatf("rdata%0d", i), 32'(rd[i]), 32'(e.d));
          chk($sformatf("latency%0d", i), cyc, e.due);
        end
      end else if (q[i].size() != 0 && q[i][0].due <= cyc) begin
        chk($sformatf("rvalid%0d_missing", i), 32'(rv[i]), 1);
        void'(q[i].pop_front());
      end
    end
  end
  // reference model: applies one cycle of the driven inputs, then lets the clock run
  task automatic step();
    logic busy, ea_w, ea_r, eb_w, eb_r;
    logic [DW-1:0] old;
    busy = (ctr != 0);
    ea_w = we_a && !busy;
    ea_r = re_a && !busy;
    eb_w = we_b && !busy;
    eb_r = re_b && !busy;
    e_coll = ea_w && eb_w && (addr_a == addr_b);
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) q[i].delete();
      ctr = 0;
      e_coll = 1'b0;
    end else begin
      if (ea_r) begin
        old = mem[addr_a];
        q[0].push_back(exp_t'{old, cyc + 1});
        q[2].push_back(exp_t'{(eb_w && !e_coll && addr_b == addr_a) ? wdata_b : old, cyc + 2});
      end
      if (eb_r) begin
        old = mem[addr_b];
        q[1].push_back(exp_t'{old, cyc + 1});
        q[3].push_back(exp_t'{(ea_w && addr_a == addr_b) ? wdata_a : old, cyc + 2});
      end
      if (eb_w && !e_coll) mem[addr_b] = wdata_b;
      if (ea_w) mem[addr_a] = wdata_a;
      if (ctr >= 1 && ctr <= BD) for (int b = 0; b < NB; b++) mem[(ctr - 1) * NB + b] = '0;
      ctr = (ctr == 0) ? (clr_start ? 1 : 0) : ((ctr == BD + 1) ? 0 : ctr + 1);
    end
    @(negedge clk);
    {clr_start, we_a, re_a, we_b, re_b} = '0;
    rst_n = 1'b1;
    chk("collision0", 32'(if0.collision), 32'(e_coll));
    chk("collision1", 32'(if1.collision), 32'(e_coll));
    chk("clr_busy0", 32'(if0.clr_busy), 32'(ctr != 0));
    chk("clr_busy1", 32'(if1.clr_busy), 32'(ctr != 0));
    chk("clr_done0", 32'(if0.clr_done), 32'(ctr == BD + 1));
    chk("clr_done1", 32'(if1.clr_done), 32'(ctr == BD + 1));
  endtask
  task automatic chk_rst();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_rdata%0d", i), 32'(rd[i]), 0);
      chk($sformatf("rst_rvalid%0d", i), 32'(rv[i]), 0);
    end
  endtask
  function automatic logic [AW-1:0] pick();
    return ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NW - 1));
  endfunction
  task automatic rnd();
    we_a = 1'($urandom_range(0, 1));
    re_a = 1'($urandom_range(0, 1));
    we_b = 1'($urandom_range(0, 1));
    re_b = 1'($urandom_range(0, 1));
    addr_a = pick();
    addr_b = pick();
    wdata_a = DW'($urandom);
    wdata_b = DW'($urandom);
    clr_start = ($urandom_range(0, 399) == 0);
  endtask
  task automatic fill(input logic rand_data);
    for (int i = 0; i < NW / 2; i++) begin
      we_a = 1'b1;
      addr_a = AW'(2 * i);
      wdata_a = rand_data ? DW'($urandom) : 16'hFFFF;
      we_b = 1'b1;
      addr_b = AW'(2 * i + 1);
      wdata_b = rand_data ? DW'($urandom) : 16'hFFFF;
      step();
    end
  endtask
  task automatic read_all();
    for (int i = 0; i < NW / 2; i++) begin
      re_a = 1'b1;
      addr_a = AW'(2 * i);
      re_b = 1'b1;
      addr_b = AW'(2 * i + 1);
      step();
    end
  endtask
  initial begin
    int nbusy, ndone, pend;
    nbusy = 0;
    ndone = 0;
    @(negedge clk);
    rst_n = 1'b0;
    step();
    chk_rst();
    fill(1'b0);
    clr_start = 1'b1;
    step();
    for (int k = 0; k < BD + 4; k++) begin
      nbusy += int'(if0.clr_busy);
      ndone += int'(if0.clr_done);
      if (if0.clr_busy === 1'b1) begin
        rnd();
        clr_start = 1'b0;
      end
      step();
    end
    chk("clr_busy_cycles", nbusy, BD + 1);
    chk("clr_done_pulses", ndone, 1);
    read_all();
    for (int i = 0; i < 8; i++) begin
      we_a = 1'b1;
      addr_a = AW'(i);
      wdata_a = 16'h1111 + DW'(i);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      re_b = 1'b1;
      addr_b = AW'(i);
      step();
    end
    we_a = 1'b1; addr_a = 8'd5; wdata_a = 16'hAAAA;
    step();
    we_a = 1'b1; addr_a = 8'd5; wdata_a = 16'hBBBB; re_b = 1'b1; addr_b = 8'd5;
    step();
    we_a = 1'b1; addr_a = 8'd9; wdata_a = 16'h1234; we_b = 1'b1; addr_b = 8'd9; wdata_b = 16'h5678;
    step();
    re_a = 1'b1; addr_a = 8'd9; re_b = 1'b1; addr_b = 8'd9;
    step();
    for (int n = 0; n < 2000; n++) begin
      rnd();
      step();
    end
    repeat (BD + 4) step();
    fill(1'b1);
    clr_start = 1'b1;
    step();
    for (int k = 0; k < 100 && ctr != 11; k++) step();
    chk("mid_clear_reached", ctr, 11);
    rst_n = 1'b0;
    step();
    chk_rst();
    read_all();
    repeat (4) step();
    for (int i = 0; i < 4; i++) begin
      pend = q[i].size();
      chk($sformatf("drain%0d", i), pend, 0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
